// File: rtl/piso_bidir_tx_if.sv
// piso_bidir_tx_if: load handshake and serial output bundle of the bidirectional PISO transmitter.
interface piso_bidir_tx_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             dir;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, din, dir, shift_en,
        input  load_ready, sout, sout_valid, busy, done
    );

    modport slave (
        input  load_valid, din, dir, shift_en,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_bidir_tx.sv
// piso_bidir_tx: parallel-in serial-out transmitter, MSB- or LSB-first per word, gapless back-to-back loads.
module piso_bidir_tx #(
    parameter int   WIDTH = 4,
    parameter logic FILL  = 1'b0
) (
    input logic              clk,
    input logic              rst,
    piso_bidir_tx_if.slave   tx_if
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last, accept;

    assign last   = state_q == SHIFT && cnt_q == CW'(WIDTH - 1) && tx_if.shift_en;
    assign accept = tx_if.load_valid && tx_if.load_ready;
    assign done_d = last;

    assign tx_if.load_ready = state_q == IDLE || last;
    assign tx_if.sout       = state_q == SHIFT ? (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]) : 1'b0;
    assign tx_if.sout_valid = state_q == SHIFT;
    assign tx_if.busy       = state_q == SHIFT;
    assign tx_if.done       = done_q;

    // A load on the last-bit edge takes priority over the shift, keeping the stream gapless.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = tx_if.din;
            dir_d   = tx_if.dir;
            cnt_d   = '0;
        end else if (state_q == SHIFT && tx_if.shift_en) begin
            shreg_d = dir_q ? {FILL, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], FILL};
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            state_d = last ? IDLE : SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_piso_bidir_tx.sv
// tb_piso_bidir_tx: randomized scoreboard bench; each accepted word is expanded into its expected bit stream.
module tb_piso_bidir_tx;
    localparam int W = 4;

    typedef struct {
        logic b;
        logic last;
    } bit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit_t exp_q[$];
    logic done_exp = 1'b0;

    piso_bidir_tx_if #(.WIDTH(W)) tx_if ();
    piso_bidir_tx_if #(.WIDTH(W)) f_if ();

    piso_bidir_tx #(.WIDTH(W), .FILL(1'b0)) dut (.clk(clk), .rst(rst), .tx_if(tx_if.slave));
    piso_bidir_tx #(.WIDTH(W), .FILL(1'b1)) dut_f (.clk(clk), .rst(rst), .tx_if(f_if.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard push: a word is taken only when nothing is left to send after this edge.
    always @(posedge clk) begin
        if (!rst && tx_if.load_valid && exp_q.size() == 0)
            for (int i = 0; i < W; i++)
                exp_q.push_back('{b: tx_if.dir ? tx_if.din[i] : tx_if.din[W-1-i], last: i == W - 1});
    end

    always @(posedge rst) exp_q.delete();

    // Monitor: compares the DUT's outputs with the head of the expected stream every cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", tx_if.load_ready, 1);
            chk("rst_valid", tx_if.sout_valid, 0);
            chk("rst_done", tx_if.done, 0);
            chk("rst_sout", tx_if.sout, 0);
            done_exp = 1'b0;
        end else begin
            chk("ready", tx_if.load_ready, exp_q.size() == 0 || (exp_q.size() == 1 && tx_if.shift_en));
            chk("valid", tx_if.sout_valid, exp_q.size() != 0);
            chk("busy", tx_if.busy, exp_q.size() != 0);
            chk("done", tx_if.done, done_exp);
            if (exp_q.size() != 0) begin
                chk("sout", tx_if.sout, exp_q[0].b);
                done_exp = tx_if.shift_en && exp_q[0].last;
                if (tx_if.shift_en) void'(exp_q.pop_front());
            end else begin
                chk("idle_sout", tx_if.sout, 0);
                done_exp = 1'b0;
            end
        end
    end

    task automatic drive(input logic lv, input logic [W-1:0] d, input logic dr, input logic se, input int n);
        tx_if.load_valid = lv;
        tx_if.din        = d;
        tx_if.dir        = dr;
        tx_if.shift_en   = se;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tx_if.load_valid = 1'b0;
        tx_if.din        = '0;
        tx_if.dir        = 1'b0;
        tx_if.shift_en   = 1'b1;
        f_if.load_valid  = 1'b0;
        f_if.din         = '0;
        f_if.dir         = 1'b0;
        f_if.shift_en    = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(0, '0, 0, 1, 1);
        drive(1, 4'b1011, 0, 1, 1);
        drive(0, '0, 0, 1, 6);
        drive(1, 4'b1011, 1, 1, 1);
        drive(0, '0, 0, 1, 6);
        drive(1, 4'b1100, 0, 1, 1);
        drive(1, 4'b0011, 1, 1, 4);
        drive(0, '0, 0, 1, 6);
        drive(1, 4'b1001, 0, 1, 1);
        drive(0, '0, 0, 1, 2);
        drive(1, 4'b0110, 1, 0, 3);
        drive(0, '0, 0, 1, 5);
        drive(1, 4'b1111, 0, 1, 1);
        drive(0, '0, 0, 1, 2);
        rst = 1'b1;
        #1;
        chk("async_valid", tx_if.sout_valid, 0);
        chk("async_busy", tx_if.busy, 0);
        chk("async_ready", tx_if.load_ready, 1);
        chk("async_sout", tx_if.sout, 0);
        chk("async_done", tx_if.done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 4'b0101, 0, 1, 1);
        drive(0, '0, 0, 1, 6);
        // FILL=1 instance: vacated positions fill with ones yet never reach sout.
        f_if.load_valid = 1'b1;
        @(posedge clk);
        #1 f_if.load_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("fill_shreg", dut_f.shreg_q, 4'b1111);
        chk("fill_sout", f_if.sout, 0);
        chk("fill_busy", f_if.busy, 0);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #1;
                chk("rand_rst_valid", tx_if.sout_valid, 0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
            drive(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1);
        end
        drive(0, '0, 0, 1, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_bidir_tx.md
Name: piso_bidir_tx

Overview:
- Parallel-in, serial-out transmitter: the serializer counterpart to the team's serial-in bidirectional shift register.
- Accepts a WIDTH-bit word over a valid/ready load handshake.
- Shifts the word out one bit per enabled cycle, MSB-first or LSB-first as selected per word.
- Sits ahead of any serial link whose receiver is the bidirectional shift register; the shift enable is driven by a bit-rate tick or tied high.

Parameters:
- WIDTH, 4, word width in bits; legal values 2..32.
- FILL, 1'b0, bit value shifted into the vacated end of the shift register.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  din/dir are presented for loading.
- load_ready  output  1  transmitter can accept a word this cycle.
- din  input  WIDTH  parallel word to transmit.
- dir  input  1  0 = MSB-first (left shift), 1 = LSB-first (right shift); sampled with din.
- shift_en  input  1  advance one bit this cycle; 0 = hold current bit.
- sout  output  1  serial data.
- sout_valid  output  1  sout carries a data bit.
- busy  output  1  a word is in flight.
- done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset (async, any time, including mid-word): state=IDLE, shreg=0, dir_q=0, cnt=0, done=0. This gives load_ready=1, sout=0, sout_valid=0, busy=0. A partially sent word is discarded; no done pulse is produced.
- States: IDLE and SHIFT.
- Load acceptance: a word is accepted on a rising edge when load_valid & load_ready. On acceptance: shreg<=din, dir_q<=dir, cnt<=0, state<=SHIFT. din/dir are ignored when not accepted, with no error flag.
- load_ready (combinational):
  - 1 in IDLE.
  - 1 in SHIFT when cnt==WIDTH-1 && shift_en, i.e. on the last-bit consume edge.
  - 0 otherwise.
- sout (combinational): dir_q==0 ? shreg[WIDTH-1] : shreg[0] while in SHIFT; 0 in IDLE.
- sout_valid = busy = (state==SHIFT).
- Latency: the first bit appears on sout in the cycle after the acceptance edge.
- Each bit is consumed on the edge where shift_en=1:
  - dir_q=0: shreg<={shreg[WIDTH-2:0],FILL}.
  - dir_q=1: shreg<={FILL,shreg[WIDTH-1:1]}.
  - cnt<=cnt+1.
- With shift_en=0 in SHIFT, shreg, cnt and sout hold (stall of any length).
- Last-bit edge (cnt==WIDTH-1 && shift_en):
  - done<=1 for exactly one cycle.
  - If load_valid is also 1: the new word is accepted on the same edge. shreg/dir_q/cnt reload and the state stays SHIFT, giving gapless back-to-back streaming with no idle bit.
  - Otherwise: state<=IDLE.
- done is registered. It is high in the cycle following the last-bit edge, coincident with either IDLE or the first bit of the next word.
- cnt is $clog2(WIDTH) bits, never exceeds WIDTH-1, and resets to 0 on every acceptance.
- A word occupies exactly WIDTH shift_en-high cycles in SHIFT. With shift_en tied high, load-to-done spans WIDTH+1 edges.
- dir changes while busy have no effect on the word in flight.

Test Plan:
- WIDTH=4, shift_en=1, load din=4'b1011 dir=0 -> sout=1,0,1,1 over cycles 1-4 after acceptance; sout_valid high for exactly those 4 cycles; done high in cycle 5; load_ready 0 during cycles 1-3.
- Same word with dir=1 -> sout=1,1,0,1 (LSB first); done timing identical.
- Back-to-back: 4'b1100 dir=0, then load_valid held with 4'b0011 dir=1 -> sout=1,1,0,0,1,1,0,0 contiguous; second acceptance on the first word's last-bit edge; sout_valid never drops; done pulses once after each word.
- Stall: 4'b1001 dir=0 with shift_en low for 3 cycles after the second bit -> sout holds 0 through the stall, then continues 0,1; done only after the 4th consumed bit; load_valid asserted mid-word is ignored (no reload, busy stays 1).
- Reset mid-word: assert rst after 2 bits of 4'b1111 -> immediately sout=0, sout_valid=0, busy=0, load_ready=1, done=0. After release, load 4'b0101 dir=0 -> sout=0,1,0,1 with no residue from the aborted word.
- FILL=1, WIDTH=4: after 4'b0000 dir=0 completes, shreg reads 4'b1111 internally; sout is 0 in IDLE, showing FILL never leaks to sout.
